// File: rtl/apb_irq_ctrl_if.sv
// APB slave bus bundle for apb_irq_ctrl.
// The master modport drives the request side; the slave modport returns data.
interface apb_irq_ctrl_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: edge/level sources, sticky pending, highest-index arbitration.
// Define IRQ_SYNC_EN to insert a 2-flop synchroniser on every source line.
module apb_irq_ctrl #(
    parameter int NUM_IRQ        = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int ID_WIDTH       = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    apb_irq_ctrl_if.slave       apb,
    input  logic [NUM_IRQ-1:0]  irq_src_i,
    output logic                irq_req_o,
    output logic [ID_WIDTH-1:0] irq_id_o,
    input  logic                irq_ack_i,
    input  logic [ID_WIDTH-1:0] irq_ack_id_i
);

    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_SET     = 3'd2;
    localparam logic [2:0] REG_MODE    = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] src;
    logic [NUM_IRQ-1:0] src_d;
    logic [NUM_IRQ-1:0] wdata;
    logic [NUM_IRQ-1:0] ack_vec;
    logic [NUM_IRQ-1:0] src_set;
    logic [NUM_IRQ-1:0] sw_set;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] pend_next;
    logic [NUM_IRQ-1:0] cand;
    logic [ID_WIDTH-1:0] best_id;
    logic               best_vld;
    logic               access;
    logic               wr;
    logic               mapped;
    logic [2:0]         idx;
    logic [31:0]        rdata;
    logic               unused_bits;

    assign access = apb.PSEL & apb.PENABLE;
    assign idx    = apb.PADDR[4:2];
    assign mapped = (idx <= REG_STATUS);
    assign wr     = access & apb.PWRITE & mapped;
    assign wdata  = apb.PWDATA[NUM_IRQ-1:0];

    assign unused_bits = ^{apb.PADDR, apb.PWDATA};

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q1;
    logic [NUM_IRQ-1:0] sync_q2;

    // Two-stage synchroniser for asynchronous source lines
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = irq_src_i;
`endif

    // Previous source value for rising-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_d <= '0;
        end else begin
            src_d <= src;
        end
    end

    // Per-bit set/clear terms; set wins so no edge is ever lost
    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_vec[i] = irq_ack_i &&
                ({{(32-ID_WIDTH){1'b0}}, irq_ack_id_i} == 32'(i));
        end
        src_set   = (mode & src & ~src_d) | (~mode & src);
        sw_set    = (wr && idx == REG_SET)     ? wdata : '0;
        w1c       = (wr && idx == REG_PENDING) ? wdata : '0;
        pend_next = (pending & ~(w1c | ack_vec)) | src_set | sw_set;
    end

    // Configuration and pending registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable  <= '0;
            mode    <= '0;
            pending <= '0;
        end else begin
            pending <= pend_next;
            if (wr && idx == REG_ENABLE) begin
                enable <= wdata;
            end
            if (wr && idx == REG_MODE) begin
                mode <= wdata;
            end
        end
    end

    // Highest enabled pending index wins
    always_comb begin
        cand     = pending & enable;
        best_vld = 1'b0;
        best_id  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand[i]) begin
                best_vld = 1'b1;
                best_id  = ID_WIDTH'(i);
            end
        end
    end

    // Registered request; the ID holds when nothing is requesting
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_req_o <= 1'b0;
            irq_id_o  <= '0;
        end else begin
            irq_req_o <= best_vld;
            if (best_vld) begin
                irq_id_o <= best_id;
            end
        end
    end

    // Combinational read mux; zero when deselected or unmapped
    always_comb begin
        rdata = '0;
        if (apb.PSEL) begin
            case (idx)
                REG_ENABLE:  rdata = 32'(enable);
                REG_PENDING: rdata = 32'(pending);
                REG_MODE:    rdata = 32'(mode);
                REG_STATUS:  rdata = {irq_req_o,
                                      {(31-ID_WIDTH){1'b0}},
                                      irq_id_o};
                default:     rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access & ~mapped;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed bench for apb_irq_ctrl built with NUM_IRQ=8.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_apb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    logic       ack;
    logic [4:0] ack_id;
    logic       req;
    logic [4:0] id;
    logic [31:0] d;
    logic       e;
    int         errors = 0;
    int         checks = 0;

    apb_irq_ctrl_if #(.APB_ADDR_WIDTH(12)) bus ();

    apb_irq_ctrl #(
        .NUM_IRQ(8),
        .APB_ADDR_WIDTH(12),
        .ID_WIDTH(5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .apb         (bus),
        .irq_src_i   (src),
        .irq_req_o   (req),
        .irq_id_o    (id),
        .irq_ack_i   (ack),
        .irq_ack_id_i(ack_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.PADDR   = a;
        bus.PWDATA  = v;
        bus.PWRITE  = 1'b1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        @(negedge clk);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v,
                      output logic err);
        @(negedge clk);
        bus.PADDR   = a;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        #1;
        v   = bus.PRDATA;
        err = bus.PSLVERR;
        @(negedge clk);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic ack_pulse(input logic [4:0] n);
        @(negedge clk);
        ack    = 1'b1;
        ack_id = n;
        @(negedge clk);
        ack    = 1'b0;
    endtask

    initial begin
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        rst    = 1'b1;
        src    = '0;
        ack    = 1'b0;
        ack_id = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_id", 32'(id), 32'h0);
        chk("rst_prdata", bus.PRDATA, 32'h0);
        chk("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
        chk("pready", 32'(bus.PREADY), 32'h1);
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            rd(12'(r * 4), d, e);
            chk($sformatf("rst_reg%0d", r), d, 32'h0);
            chk($sformatf("rst_err%0d", r), 32'(e), 32'h0);
        end
        rd(12'h018, d, e);
        chk("unmap_data", d, 32'h0);
        chk("unmap_err", 32'(e), 32'h1);

        // edge mode on line 3
        wr(12'h00C, 32'h8);
        wr(12'h000, 32'h8);
        @(negedge clk);
        src[3] = 1'b1;
        @(negedge clk);
        src[3] = 1'b0;
        chk("edge_req_lag", 32'(req), 32'h0);
        @(negedge clk);
        chk("edge_req", 32'(req), 32'h1);
        chk("edge_id", 32'(id), 32'd3);
        rd(12'h004, d, e);
        chk("edge_pend", d, 32'h8);
        ack_pulse(5'd3);
        chk("ack_req_hold", 32'(req), 32'h1);
        @(negedge clk);
        chk("ack_req_drop", 32'(req), 32'h0);
        chk("ack_id_hold", 32'(id), 32'd3);

        // level mode on lines 4 and 5
        wr(12'h00C, 32'h0);
        wr(12'h000, 32'h30);
        @(negedge clk);
        src[5:4] = 2'b11;
        repeat (2) @(negedge clk);
        chk("lvl_req", 32'(req), 32'h1);
        chk("lvl_id5", 32'(id), 32'd5);
        ack_pulse(5'd5);
        @(negedge clk);
        chk("lvl_reack_id", 32'(id), 32'd5);
        rd(12'h004, d, e);
        chk("lvl_pend", d, 32'h30);
        @(negedge clk);
        src[5] = 1'b0;
        ack    = 1'b1;
        ack_id = 5'd5;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        chk("lvl_id4", 32'(id), 32'd4);
        chk("lvl_req4", 32'(req), 32'h1);
        src[4] = 1'b0;
        wr(12'h000, 32'h0);
        chk("en_clr_lag", 32'(req), 32'h1);
        @(negedge clk);
        chk("en_clr_req", 32'(req), 32'h0);
        rd(12'h004, d, e);
        chk("en_clr_pend", d, 32'h10);
        wr(12'h004, 32'h10);
        rd(12'h004, d, e);
        chk("w1c_pend", d, 32'h0);

        // set wins over W1C on line 7
        wr(12'h00C, 32'h80);
        wr(12'h008, 32'h80);
        rd(12'h004, d, e);
        chk("set7_pend", d, 32'h80);
        @(negedge clk);
        bus.PADDR   = 12'h004;
        bus.PWDATA  = 32'h80;
        bus.PWRITE  = 1'b1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        src[7]      = 1'b1;
        @(negedge clk);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        rd(12'h004, d, e);
        chk("setwins_pend", d, 32'h80);
        wr(12'h004, 32'h80);
        rd(12'h004, d, e);
        chk("edge_held_pend", d, 32'h0);
        src[7] = 1'b0;

        // software set while disabled, then enable
        wr(12'h008, 32'h1);
        rd(12'h004, d, e);
        chk("sw_pend", d, 32'h1);
        chk("sw_req_off", 32'(req), 32'h0);
        wr(12'h000, 32'h1);
        @(negedge clk);
        chk("sw_req_on", 32'(req), 32'h1);
        rd(12'h010, d, e);
        chk("status", d, 32'h8000_0000);
        wr(12'h004, 32'h1);

        // bits above NUM_IRQ and out-of-range ack
        wr(12'h000, 32'hFFFF_FFFF);
        rd(12'h000, d, e);
        chk("en_mask", d, 32'h0000_00FF);
        wr(12'h00C, 32'hFFFF_FFFF);
        rd(12'h00C, d, e);
        chk("mode_mask", d, 32'h0000_00FF);
        wr(12'h00C, 32'h0);
        wr(12'h008, 32'hFFFF_FF04);
        rd(12'h004, d, e);
        chk("set_mask", d, 32'h4);
        chk("id2_req", 32'(req), 32'h1);
        chk("id2", 32'(id), 32'd2);
        ack_pulse(5'd20);
        @(negedge clk);
        chk("ack20_req", 32'(req), 32'h1);
        chk("ack20_id", 32'(id), 32'd2);
        rd(12'h004, d, e);
        chk("ack20_pend", d, 32'h4);
        rd(12'h008, d, e);
        chk("set_reads0", d, 32'h0);
        wr(12'h01C, 32'h0);
        rd(12'h000, d, e);
        chk("unmap_wr_ign", d, 32'hFF);

        // reset in the middle of an active request
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_req", 32'(req), 32'h0);
        chk("mid_rst_id", 32'(id), 32'h0);
        rd(12'h000, d, e);
        chk("mid_rst_en", d, 32'h0);
        rd(12'h004, d, e);
        chk("mid_rst_pend", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
